serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  minuend; captured on the accepting edge only.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepting edge only.
REQ-007 busy  output  1  high while bits are being processed (SHIFT state).
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; high when unsigned a < b.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL be the accepting edge E: load a and b into shift registers, clear the borrow register and the bit counter, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit, LSB first, using a full-subtractor cell:
- d = a0 ^ b0 ^ bin
- bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
REQ-014 On each SHIFT edge, d SHALL shift into the result register from the MSB end, bout SHALL be stored as the next bin, and both operand registers SHALL shift right by one.
REQ-015 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL not wrap during a 32-bit operation.
REQ-016 Edges E+1 through E+WIDTH SHALL process bits 0 through WIDTH-1; edge E+WIDTH SHALL enter DONE.
REQ-017 done SHALL be 1 for exactly the one cycle following edge E+WIDTH (latency WIDTH+1 edges from the accepting edge).
REQ-018 busy SHALL be 1 exactly while the state is SHIFT; busy and done SHALL never both be 1.
REQ-019 diff and borrow_out SHALL update only on the edge that enters DONE, and SHALL hold until the next operation completes.
REQ-020 In DONE with start=0, the next edge SHALL enter IDLE.
REQ-021 In DONE with start=1, the next edge SHALL accept a new operation (back-to-back, no idle cycle).
REQ-022 start during SHIFT SHALL be ignored; changes on a and b outside the accepting edge SHALL have no effect.
REQ-023 For a == b, the block SHALL produce diff=0, borrow_out=0.
REQ-024 For a=0, b=2^WIDTH-1, the block SHALL produce diff=1, borrow_out=1.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force:
- state to IDLE
- busy=0, done=0
- diff=0, borrow_out=0
- all internal shift, borrow and counter registers to 0
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-027 After rst_n rises, the first accepting edge SHALL be the first rising edge with start=1.

Configuration
REQ-028 The macro SERIAL_SUB_OVERFLOW_EN SHALL control one feature: a signed-overflow output.
REQ-029 With SERIAL_SUB_OVERFLOW_EN defined, the module SHALL have an extra output port ovf (output, 1 bit) that:
- is 1 when the two's-complement result overflows, i.e. a[MSB] != b[MSB] and diff[MSB] != a[MSB]
- updates and holds with diff (REQ-019)
- resets to 0
REQ-030 Without the macro, port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-031 a=0x35, b=0x12, start pulse -> done 9 edges after acceptance, diff=0x23, borrow_out=0, ovf=0.
REQ-032 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1, ovf=0.
REQ-033 a=0x80, b=0x01, macro defined -> diff=0x7F, borrow_out=0, ovf=1.
REQ-034 start re-pulsed with a=0xFF, b=0xFF at the 3rd SHIFT cycle of the 0x35-0x12 operation -> ignored; result 0x23 with a single done pulse.
REQ-035 rst_n driven low at the 4th SHIFT cycle -> busy, done and diff are 0 immediately; no done pulse; a new 0x10-0x10 operation then gives diff=0x00, borrow_out=0.
REQ-036 start held at 1 in the DONE cycle with a=0x01, b=0x02 -> accepted immediately; next done gives diff=0xFF, borrow_out=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b, LSB first, one bit per clock through a full-subtractor cell.
// Optional signed-overflow output `ovf` is built only when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             bin_q,    bin_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic             ovf_q,    ovf_d;
`endif

  logic bit_d;
  logic bit_bout;

  // Full-subtractor cell on the current LSBs of the operand shifters.
  always_comb begin
    bit_d    = a_sh_q[0] ^ b_sh_q[0] ^ bin_q;
    bit_bout = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bin_q);
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        res_d  = {bit_d, res_q[WIDTH-1:1]};
        bin_d  = bit_bout;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // Publish on the final bit so results change only when entering DONE.
        if (cnt_q == LAST) begin
          state_d  = DONE;
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = bit_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases, random operands,
// start-during-shift, reset mid-shift and back-to-back against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int vectors;
  int miscompares;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, s;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    s  = sx - sy;
    return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
  endfunction

  // Runs one operation from the accepting edge up to the DONE cycle (k = edges after acceptance).
  // Optionally re-pulses start with all-ones operands at SHIFT cycle inj_k.
  task automatic drive_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int inj_k,
                          output int done_at, output int pulses, output int busy_bad,
                          output int hold_bad);
    logic [W-1:0] d0;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    done_at = -1; pulses = 0; busy_bad = 0; hold_bad = 0;
    d0 = diff;
    for (int k = 0; k <= W; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == inj_k) begin
        start = 1'b1; a = '1; b = '1;
      end else if (k == inj_k + 1) begin
        start = 1'b0; a = W'($urandom); b = W'($urandom);
      end
      if (done) begin pulses++; done_at = k; end
      if (busy !== (k < W)) busy_bad++;
      if (busy && done) busy_bad++;
      if (k < W && diff !== d0) hold_bad++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #2;
    vectors++;
    if ({busy, done, diff, borrow_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b, want all 0",
               busy, done, diff, borrow_out);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    start = 1'b1; a = 8'h55; b = 8'h0F;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got busy=%b done=%b want 0 0 while rst_n low", busy, done);
    end
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b want 0 with start low", busy);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [6] = '{8'h35, 8'h00, 8'h80, 8'h5A, 8'h00, 8'hFF};
    logic [W-1:0] tb [6] = '{8'h12, 8'h01, 8'h01, 8'h5A, 8'hFF, 8'hFF};
    int done_at, pulses, busy_bad, hold_bad;
    for (int i = 0; i < 6; i++) begin
      drive_op(ta[i], tb[i], -10, done_at, pulses, busy_bad, hold_bad);
      vectors++;
      if (diff !== ref_diff(ta[i], tb[i]) || borrow_out !== ref_borrow(ta[i], tb[i])) begin
        miscompares++;
        $display("FAIL directed_%0d result: got diff=%h borrow=%b want diff=%h borrow=%b",
                 i, diff, borrow_out, ref_diff(ta[i], tb[i]), ref_borrow(ta[i], tb[i]));
      end
      vectors++;
      if (done_at !== W || pulses !== 1) begin
        miscompares++;
        $display("FAIL directed_%0d latency: got done at edge %0d (%0d pulses) want edge %0d (1 pulse)",
                 i, done_at + 1, pulses, W + 1);
      end
      vectors++;
      if (busy_bad !== 0 || hold_bad !== 0) begin
        miscompares++;
        $display("FAIL directed_%0d busy_hold: got busy errors=%0d hold errors=%0d want 0 0",
                 i, busy_bad, hold_bad);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      vectors++;
      if (ovf !== ref_ovf(ta[i], tb[i])) begin
        miscompares++;
        $display("FAIL directed_%0d ovf: got %b want %b", i, ovf, ref_ovf(ta[i], tb[i]));
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb, held;
    int done_at, pulses, busy_bad, hold_bad;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      drive_op(ra, rb, -10, done_at, pulses, busy_bad, hold_bad);
      vectors++;
      if (diff !== ref_diff(ra, rb) || borrow_out !== ref_borrow(ra, rb) ||
          done_at !== W || pulses !== 1 || busy_bad !== 0 || hold_bad !== 0) begin
        miscompares++;
        $display("FAIL random_%0d a=%h b=%h: got diff=%h borrow=%b done_edge=%0d busy_err=%0d hold_err=%0d want diff=%h borrow=%b done_edge=%0d",
                 i, ra, rb, diff, borrow_out, done_at + 1, busy_bad, hold_bad,
                 ref_diff(ra, rb), ref_borrow(ra, rb), W + 1);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      vectors++;
      if (ovf !== ref_ovf(ra, rb)) begin
        miscompares++;
        $display("FAIL random_%0d ovf: got %b want %b", i, ovf, ref_ovf(ra, rb));
      end
`endif
      held = diff;
      repeat (1 + (i % 3)) begin
        @(posedge clk); #1;
      end
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== held) begin
        miscompares++;
        $display("FAIL random_%0d idle: got done=%b busy=%b diff=%h want 0 0 %h",
                 i, done, busy, diff, held);
      end
    end
  endtask

  task automatic test_start_during_shift;
    int done_at, pulses, busy_bad, hold_bad;
    drive_op(8'h35, 8'h12, 2, done_at, pulses, busy_bad, hold_bad);
    vectors++;
    if (diff !== 8'h23 || borrow_out !== 1'b0 || pulses !== 1 || done_at !== W || busy_bad !== 0) begin
      miscompares++;
      $display("FAIL start_in_shift: got diff=%h borrow=%b pulses=%0d done_edge=%0d busy_err=%0d want 23 0 1 %0d 0",
               diff, borrow_out, pulses, done_at + 1, busy_bad, W + 1);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_shift_after: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_shift;
    int done_seen;
    int done_at, pulses, busy_bad, hold_bad;
    a = 8'h35; b = 8'h12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got busy=%b done=%b diff=%h borrow=%b want 0 0 00 0",
               busy, done, diff, borrow_out);
    end
    done_seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
      if (i == 1) rst_n = 1'b1;
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_no_done: got %0d done pulses want 0", done_seen);
    end
    drive_op(8'h10, 8'h10, -10, done_at, pulses, busy_bad, hold_bad);
    vectors++;
    if (diff !== 8'h00 || borrow_out !== 1'b0 || done_at !== W || pulses !== 1) begin
      miscompares++;
      $display("FAIL rst_mid_recover: got diff=%h borrow=%b done_edge=%0d want 00 0 %0d",
               diff, borrow_out, done_at + 1, W + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int done_at, pulses, busy_bad, hold_bad;
    drive_op(8'h35, 8'h12, -10, done_at, pulses, busy_bad, hold_bad);
    vectors++;
    if (diff !== 8'h23 || borrow_out !== 1'b0 || done_at !== W) begin
      miscompares++;
      $display("FAIL b2b_first: got diff=%h borrow=%b done_edge=%0d want 23 0 %0d",
               diff, borrow_out, done_at + 1, W + 1);
    end
    drive_op(8'h01, 8'h02, -10, done_at, pulses, busy_bad, hold_bad);
    vectors++;
    if (diff !== 8'hFF || borrow_out !== 1'b1 || done_at !== W || pulses !== 1 || busy_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_second: got diff=%h borrow=%b done_edge=%0d pulses=%0d busy_err=%0d want FF 1 %0d 1 0",
               diff, borrow_out, done_at + 1, pulses, busy_bad, W + 1);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'hFF) begin
      miscompares++;
      $display("FAIL b2b_idle: got done=%b busy=%b diff=%h want 0 0 FF", done, busy, diff);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_during_shift();
    test_reset_mid_shift();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
